// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; HI = remainder, LO = quotient.
// Optional macro DIV_EARLY_EXIT_EN: finish at accept when |dividend| < |divisor|.
module hilo_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic              we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_BYZERO = 2'b01,
    ST_ON     = 2'b10,
    ST_END    = 2'b11
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [2*DATA_W:0]   div_reg, div_next;
  logic [DATA_W-1:0]   divisor_reg, divisor_next;
  logic                neg_q_reg, neg_q_next;
  logic                neg_r_reg, neg_r_next;
  logic [DATA_W-1:0]   hi_reg, hi_next;
  logic [DATA_W-1:0]   lo_reg, lo_next;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W+1:0]   diff;
  logic [2*DATA_W:0]   iter_val;
  logic [DATA_W-1:0]   quo, rem;

  assign op1_neg = signed_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_i & opdata2_i[DATA_W-1];
  assign abs1    = op1_neg ? -opdata1_i : opdata1_i;
  assign abs2    = op2_neg ? -opdata2_i : opdata2_i;

  // Trial subtract on the left-shifted partial remainder; the top bit of
  // div_reg is always zero, so it doubles as the guard bit for the borrow.
  assign diff     = div_reg[2*DATA_W:DATA_W-1] - {2'b00, divisor_reg};
  assign iter_val = diff[DATA_W+1] ? {div_reg[2*DATA_W-1:0], 1'b0}
                                   : {diff[DATA_W:0], div_reg[DATA_W-2:0], 1'b1};
  assign quo      = iter_val[DATA_W-1:0];
  assign rem      = iter_val[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FREE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      div_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      divisor_reg <= divisor_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    div_next     = div_reg;
    divisor_next = divisor_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    busy_o       = 1'b0;
    ready_o      = 1'b0;

    case (state_reg)
      ST_FREE: begin
        if (start_i && !annul_i) begin
          neg_q_next   = op1_neg ^ op2_neg;
          neg_r_next   = op1_neg;
          divisor_next = abs2;
          div_next     = {{(DATA_W+1){1'b0}}, abs1};
          cnt_next     = '0;
          if (opdata2_i == '0) begin
            state_next = ST_BYZERO;
`ifdef DIV_EARLY_EXIT_EN
          end else if (abs1 < abs2) begin
            state_next = ST_END;
            hi_next    = opdata1_i;
            lo_next    = '0;
`endif
          end else begin
            state_next = ST_ON;
          end
        end
      end
      ST_BYZERO: begin
        busy_o = 1'b1;
        if (annul_i) begin
          state_next = ST_FREE;
        end else begin
          state_next = ST_END;
          hi_next    = '0;
          lo_next    = '0;
        end
      end
      ST_ON: begin
        busy_o = 1'b1;
        if (annul_i) begin
          state_next = ST_FREE;
          cnt_next   = '0;
        end else begin
          div_next = iter_val;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(DATA_W-1)) begin
            state_next = ST_END;
            hi_next    = neg_r_reg ? -rem : rem;
            lo_next    = neg_q_reg ? -quo : quo;
          end
        end
      end
      ST_END: begin
        ready_o    = !annul_i;
        state_next = ST_FREE;
      end
      default: state_next = ST_FREE;
    endcase
  end

  assign we_o = ready_o;
  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule
